// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase, expose, ramp-ADC convert and row-by-row readout
// with a valid/ready output stream, single-shot or continuous capture and abort.
module pixel_array_ctrl #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ERASE_CYC   = 5,
    parameter int unsigned READ_SETTLE = 2,
    parameter int unsigned EXP_W       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   continuous,
    input  logic                                   abort,
    input  logic [EXP_W-1:0]                       expose_cycles,
    output logic                                   erase,
    output logic                                   expose,
    output logic                                   convert,
    output logic [DATA_W-1:0]                      adc_count,
    output logic [ROWS-1:0]                        read,
    input  logic [COLS*DATA_W-1:0]                 row_data,
    output logic [COLS*DATA_W-1:0]                 out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                                   out_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic [15:0]                            frame_cnt
);

    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned BUS_W   = COLS * DATA_W;
    localparam int unsigned ER_W    = $clog2(ERASE_CYC + 1);
    localparam int unsigned RS_W    = $clog2(READ_SETTLE + 1);
    localparam int unsigned SMALL_W = (ER_W > RS_W) ? ER_W : RS_W;
    localparam int unsigned CNT_W   = (EXP_W > SMALL_W) ? EXP_W : SMALL_W;

    localparam logic [2:0] IDLE          = 3'd0;
    localparam logic [2:0] ERASE         = 3'd1;
    localparam logic [2:0] EXPOSE        = 3'd2;
    localparam logic [2:0] CONVERT       = 3'd3;
    localparam logic [2:0] READ_SETTLE_S = 3'd4;
    localparam logic [2:0] READ_OUT      = 3'd5;
    localparam logic [2:0] DONE          = 3'd6;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ROW_W-1:0]  row, row_n;
    logic [EXP_W-1:0]  exp_len, exp_len_n;

    logic              erase_n, expose_n, convert_n;
    logic [DATA_W-1:0] adc_n;
    logic [ROWS-1:0]   read_n;
    logic [BUS_W-1:0]  out_data_n;
    logic [ROW_W-1:0]  out_row_n;
    logic              out_last_n, out_valid_n, busy_n, frame_done_n;
    logic [15:0]       frame_cnt_n;

    // Next state and next registered outputs
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        exp_len_n    = exp_len;
        erase_n      = 1'b0;
        expose_n     = 1'b0;
        convert_n    = 1'b0;
        adc_n        = '0;
        read_n       = '0;
        out_data_n   = out_data;
        out_row_n    = out_row;
        out_last_n   = out_last;
        out_valid_n  = out_valid;
        frame_done_n = 1'b0;
        frame_cnt_n  = frame_cnt;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    exp_len_n = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
                    state_n   = ERASE;
                    cnt_n     = '0;
                    erase_n   = 1'b1;
                end
            end
            ERASE: begin
                if (cnt == CNT_W'(ERASE_CYC - 1)) begin
                    state_n  = EXPOSE;
                    cnt_n    = '0;
                    expose_n = 1'b1;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    erase_n = 1'b1;
                end
            end
            EXPOSE: begin
                if (cnt == CNT_W'(exp_len - EXP_W'(1))) begin
                    state_n   = CONVERT;
                    cnt_n     = '0;
                    convert_n = 1'b1;
                end else begin
                    cnt_n    = cnt + CNT_W'(1);
                    expose_n = 1'b1;
                end
            end
            CONVERT: begin
                if (adc_count == {DATA_W{1'b1}}) begin
                    state_n = READ_SETTLE_S;
                    cnt_n   = '0;
                    row_n   = '0;
                    read_n  = ROWS'(1);
                end else begin
                    convert_n = 1'b1;
                    adc_n     = adc_count + DATA_W'(1);
                end
            end
            READ_SETTLE_S: begin
                if (cnt == CNT_W'(READ_SETTLE - 1)) begin
                    state_n     = READ_OUT;
                    out_data_n  = row_data;
                    out_row_n   = row;
                    out_last_n  = (row == ROW_W'(ROWS - 1));
                    out_valid_n = 1'b1;
                end else begin
                    cnt_n  = cnt + CNT_W'(1);
                    read_n = ROWS'(1) << row;
                end
            end
            READ_OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    if (row != ROW_W'(ROWS - 1)) begin
                        state_n = READ_SETTLE_S;
                        cnt_n   = '0;
                        row_n   = row + ROW_W'(1);
                        read_n  = ROWS'(1) << (row + ROW_W'(1));
                    end else begin
                        state_n      = DONE;
                        frame_done_n = 1'b1;
                        frame_cnt_n  = frame_cnt + 16'd1;
                    end
                end
            end
            DONE: begin
                if (continuous) begin
                    exp_len_n = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
                    state_n   = ERASE;
                    cnt_n     = '0;
                    erase_n   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides everything, including a completing handshake
        if (abort && (state != IDLE)) begin
            state_n      = IDLE;
            erase_n      = 1'b0;
            expose_n     = 1'b0;
            convert_n    = 1'b0;
            adc_n        = '0;
            read_n       = '0;
            out_valid_n  = 1'b0;
            frame_done_n = 1'b0;
            frame_cnt_n  = frame_cnt;
        end

        busy_n = (state_n != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            exp_len    <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            adc_count  <= '0;
            read       <= '0;
            out_data   <= '0;
            out_row    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            exp_len    <= exp_len_n;
            erase      <= erase_n;
            expose     <= expose_n;
            convert    <= convert_n;
            adc_count  <= adc_n;
            read       <= read_n;
            out_data   <= out_data_n;
            out_row    <= out_row_n;
            out_last   <= out_last_n;
            out_valid  <= out_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: frame timeline reference model with random row data
// and backpressure, plus abort, reset and a single-row build.
module tb_pixel_array_ctrl;

    localparam int ROWS        = 2;
    localparam int COLS        = 2;
    localparam int DATA_W      = 8;
    localparam int ERASE_CYC   = 5;
    localparam int READ_SETTLE = 2;
    localparam int EXP_W       = 16;
    localparam int BUS_W       = COLS * DATA_W;
    localparam int CONV_CYC    = 1 << DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, start1, continuous, abort, out_ready, out_ready1;
    logic [EXP_W-1:0]  expose_cycles;
    logic [BUS_W-1:0]  row_data;

    logic              erase, expose, convert, out_last, out_valid, busy, frame_done;
    logic [DATA_W-1:0] adc_count;
    logic [ROWS-1:0]   read;
    logic [BUS_W-1:0]  out_data;
    logic [0:0]        out_row;
    logic [15:0]       frame_cnt;

    logic              erase1, expose1, convert1, out_last1, out_valid1, busy1, frame_done1;
    logic [DATA_W-1:0] adc_count1;
    logic [0:0]        read1;
    logic [BUS_W-1:0]  out_data1;
    logic [0:0]        out_row1;
    logic [15:0]       frame_cnt1;

    pixel_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ERASE_CYC(ERASE_CYC),
                       .READ_SETTLE(READ_SETTLE), .EXP_W(EXP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
        .expose_cycles(expose_cycles), .erase(erase), .expose(expose), .convert(convert),
        .adc_count(adc_count), .read(read), .row_data(row_data), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    pixel_array_ctrl #(.ROWS(1), .COLS(COLS), .DATA_W(DATA_W), .ERASE_CYC(ERASE_CYC),
                       .READ_SETTLE(READ_SETTLE), .EXP_W(EXP_W)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .continuous(continuous), .abort(abort),
        .expose_cycles(expose_cycles), .erase(erase1), .expose(expose1), .convert(convert1),
        .adc_count(adc_count1), .read(read1), .row_data(row_data), .out_data(out_data1),
        .out_row(out_row1), .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .frame_done(frame_done1), .frame_cnt(frame_cnt1)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, {29'd0, erase, expose, convert}, 32'd0);
        chk({tag, "_adc"}, 32'(adc_count), 32'd0);
        chk({tag, "_read"}, 32'(read), 32'd0);
        chk({tag, "_odata"}, 32'(out_data), 32'd0);
        chk({tag, "_orow_last_valid"}, {29'd0, out_row, out_last, out_valid}, 32'd0);
        chk({tag, "_busy_done"}, {30'd0, busy, frame_done}, 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // Walks one frame from its first erase cycle to its DONE cycle, checking every cycle
    // against the phase lengths; capture is the row_data present at the last settle edge.
    task automatic do_frame(input int exp_len, input int stall0, input int new_exp,
                            input bit poke_start);
        logic [BUS_W-1:0] cap;
        int stall;
        for (int i = 0; i < ERASE_CYC; i++) begin
            chk("erase", {29'd0, erase, expose, convert}, 32'b100);
            chk("erase_read", 32'(read), 32'd0);
            chk("erase_busy", 32'(busy), 32'd1);
            step;
        end
        for (int i = 0; i < exp_len; i++) begin
            chk("expose", {29'd0, erase, expose, convert}, 32'b010);
            chk("expose_read", 32'(read), 32'd0);
            if (i == 0 && new_exp >= 0) expose_cycles = EXP_W'(new_exp);
            step;
        end
        for (int i = 0; i < CONV_CYC; i++) begin
            chk("convert", {29'd0, erase, expose, convert}, 32'b001);
            chk("adc_count", 32'(adc_count), 32'(i));
            start = poke_start && (i == 50);
            step;
        end
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int s = 0; s < READ_SETTLE; s++) begin
                chk("settle_read", 32'(read), 32'(1 << r));
                chk("settle_phase", {28'd0, erase, expose, convert, out_valid}, 32'd0);
                chk("settle_adc", 32'(adc_count), 32'd0);
                row_data = BUS_W'($urandom);
                cap = row_data;
                step;
            end
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_data", 32'(out_data), 32'(cap));
            chk("beat_row", 32'(out_row), 32'(r));
            chk("beat_last", 32'(out_last), 32'(r == ROWS - 1));
            chk("beat_read", 32'(read), 32'd0);
            stall = (r == 0) ? stall0 : int'($urandom_range(0, 2));
            for (int k = 0; k < stall; k++) begin
                out_ready = 1'b0;
                row_data = BUS_W'($urandom);
                step;
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(cap));
                chk("stall_row", 32'(out_row), 32'(r));
                chk("stall_read", 32'(read), 32'd0);
            end
            out_ready = 1'b1;
            step;
        end
        exp_frames++;
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_fcnt", 32'(frame_cnt), 32'(exp_frames));
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_idle;
        continuous = 1'b0;
        step;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(frame_done), 32'd0);
        chk("idle_fcnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    initial begin
        logic [BUS_W-1:0] cap1;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; continuous = 1'b0; abort = 1'b0;
        out_ready = 1'b1; out_ready1 = 1'b1; expose_cycles = '0; row_data = '0;
        step;
        chk_all_zero("reset");
        step;
        reset = 1'b0;
        step;
        chk_all_zero("post_reset");

        // Basic single-shot frame
        expose_cycles = 16'd10;
        start_frame;
        do_frame(10, 0, -1, 1'b0);
        finish_idle;

        // Backpressure on row 0 for 7 cycles
        start_frame;
        do_frame(10, 7, -1, 1'b0);
        finish_idle;

        // Continuous capture; new exposure applies only to the second frame
        continuous = 1'b1;
        start_frame;
        do_frame(10, int'($urandom_range(0, 3)), 3, 1'b0);
        step;
        do_frame(3, int'($urandom_range(0, 3)), -1, 1'b0);
        finish_idle;

        // Zero exposure clamps to one cycle; start during convert is ignored
        expose_cycles = 16'd0;
        start_frame;
        do_frame(1, 0, -1, 1'b1);
        finish_idle;
        repeat (3) step;
        chk("no_restart_busy", 32'(busy), 32'd0);

        // Abort in IDLE wins over start
        abort = 1'b1; start = 1'b1;
        step;
        abort = 1'b0; start = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_erase", 32'(erase), 32'd0);

        // Abort mid-convert
        expose_cycles = 16'd2;
        start_frame;
        repeat (ERASE_CYC + 2 + 100) step;
        chk("pre_abort_adc", 32'(adc_count), 32'd100);
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("abort_phase", {29'd0, erase, expose, convert}, 32'd0);
        chk("abort_adc", 32'(adc_count), 32'd0);
        chk("abort_busy_done", {30'd0, busy, frame_done}, 32'd0);
        chk("abort_valid_read", {29'd0, out_valid, read}, 32'd0);
        repeat (3) step;
        chk("abort_fcnt", 32'(frame_cnt), 32'(exp_frames));
        chk("abort_done_later", 32'(frame_done), 32'd0);

        // Asynchronous reset mid-expose
        expose_cycles = 16'd20;
        start_frame;
        repeat (ERASE_CYC + 3) step;
        chk("pre_reset_expose", 32'(expose), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        step;
        reset = 1'b0;
        exp_frames = 0;
        step;
        chk("after_reset_busy", 32'(busy), 32'd0);

        // Single-row build
        expose_cycles = 16'd1;
        start1 = 1'b1;
        step;
        start1 = 1'b0;
        chk("r1_erase", 32'(erase1), 32'd1);
        repeat (ERASE_CYC + 1) step;
        chk("r1_convert", {24'd0, convert1, 7'd0} | 32'(adc_count1), 32'h80);
        repeat (CONV_CYC) step;
        chk("r1_read", 32'(read1), 32'd1);
        row_data = BUS_W'($urandom);
        step;
        row_data = BUS_W'($urandom);
        cap1 = row_data;
        step;
        chk("r1_valid", 32'(out_valid1), 32'd1);
        chk("r1_row_last", {30'd0, out_row1, out_last1}, 32'b01);
        chk("r1_data", 32'(out_data1), 32'(cap1));
        step;
        chk("r1_done", 32'(frame_done1), 32'd1);
        chk("r1_fcnt", 32'(frame_cnt1), 32'd1);
        step;
        chk("r1_idle", {30'd0, busy1, out_valid1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
